// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the iterative CORDIC rotation engine:
//   FSM state type, inverse CORDIC gain constant and the arctangent table.
//   ATAN_TABLE holds atan(2^-i) scaled to 2^15/pi (a 16-bit angle word with
//   MSB weight -pi). atan_scaled() rescales an entry to other angle widths.
//   Wider words are left-shifted, so their resolution stays at 16 bits.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_SCALE,
        ST_DONE
    } cordic_state_t;

    // 1/K for the CORDIC gain K ~= 1.646760, Q1.15
    localparam int CORDIC_GAIN_INV = 19898;

    localparam int ATAN_TABLE [32] = '{
        8192, 4836, 2555, 1297, 651, 326, 163, 81,
          41,   20,   10,    5,   3,   1,   1,  0,
           0,    0,    0,    0,   0,   0,   0,  0,
           0,    0,    0,    0,   0,   0,   0,  0
    };

    function automatic int atan_scaled(input int idx, input int aw);
        int v;
        v = ATAN_TABLE[idx & 31];
        if (aw >= 16) begin
            return v << (aw - 16);
        end
        return v >> (16 - aw);
    endfunction

endpackage

// File: rtl/cordic_microrot_step.sv
// cordic_microrot_step
//   Combinational datapath for one CORDIC micro-rotation.
//   Ports:
//     x, y           current vector (guard-extended, signed)
//     z              current residual angle (wraps modulo 2^AW)
//     dir            0: counter-clockwise (z decreases), 1: clockwise
//     shift          stage index i (shift amount)
//     atan           atan(2^-i) in angle units
//     x_next, y_next, z_next   values after the micro-rotation
module cordic_microrot_step #(
    parameter int XW = 18,
    parameter int AW = 16,
    parameter int SW = 4
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic        [AW-1:0] z,
    input  logic                 dir,
    input  logic        [SW-1:0] shift,
    input  logic        [AW-1:0] atan,
    output logic signed [XW-1:0] x_next,
    output logic signed [XW-1:0] y_next,
    output logic        [AW-1:0] z_next
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        if (dir) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan;
        end
    end

endmodule

// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter
//   Iterative CORDIC rotation engine, one micro-rotation per clock.
//   Angle mode rotates (x,y) by angle_in. Micro-rotation mode applies the
//   direction vector micro_rot_in, as used for Givens rotations.
//   Ports:
//     clk, nreset            clock, asynchronous active-low reset
//     in_valid / in_ready    input handshake (in_ready high only in IDLE)
//     x_in, y_in             folded input vector, signed Q1.(DATA_WIDTH-1)
//     angle_in               folded angle, full scale +-pi
//     micro_rot_in           bit i = 1: stage i rotates clockwise
//     angle_microRot_n       1 = angle mode, 0 = micro-rotation mode
//     out_valid / out_ready  output handshake (result held until taken)
//     x_out, y_out           rotated vector, saturated to DATA_WIDTH
//     angle_out              residual angle after the last stage
//     sat_flag               x_out or y_out was clamped
//   Build option: define CORDIC_GAIN_COMP_EN to add a one-cycle SCALE state.
//   That state multiplies the result by 1/K before saturation.
module cordic_rot_iter
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int GUARD_BITS    = 2
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    x_in,
    input  logic [DATA_WIDTH-1:0]    y_in,
    input  logic [ANGLE_WIDTH-1:0]   angle_in,
    input  logic [CORDIC_STAGES-1:0] micro_rot_in,
    input  logic                     angle_microRot_n,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    x_out,
    output logic [DATA_WIDTH-1:0]    y_out,
    output logic [ANGLE_WIDTH-1:0]   angle_out,
    output logic                     sat_flag
);

    localparam int XW = DATA_WIDTH + GUARD_BITS;
    localparam int CW = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;

    cordic_state_t state;

    logic signed [XW-1:0]       xr_r;
    logic signed [XW-1:0]       yr_r;
    logic [ANGLE_WIDTH-1:0]     z_r;
    logic [CORDIC_STAGES-1:0]   dirs_r;
    logic [CW-1:0]              i_r;
    logic                       angle_mode_r;

    logic                       step_dir;
    logic [ANGLE_WIDTH-1:0]     atan_cur;
    logic signed [XW-1:0]       x_nxt;
    logic signed [XW-1:0]       y_nxt;
    logic [ANGLE_WIDTH-1:0]     z_nxt;

    // {clamped, value} for the final output registers
    logic [DATA_WIDTH:0]        res_x;
    logic [DATA_WIDTH:0]        res_y;
    logic [ANGLE_WIDTH-1:0]     res_z;

    // Drop guard bits; clamp when they are not pure sign extension
    function automatic logic [DATA_WIDTH:0] sat_drop(input logic [XW-1:0] v);
        logic [XW-DATA_WIDTH:0] top;
        top = v[XW-1:DATA_WIDTH-1];
        if ((&top) || !(|top)) begin
            return {1'b0, v[DATA_WIDTH-1:0]};
        end
        if (v[XW-1]) begin
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    always_comb begin
        step_dir = angle_mode_r ? z_r[ANGLE_WIDTH-1] : dirs_r[i_r];
        atan_cur = ANGLE_WIDTH'(atan_scaled(int'(i_r), ANGLE_WIDTH));
    end

    cordic_microrot_step #(
        .XW (XW),
        .AW (ANGLE_WIDTH),
        .SW (CW)
    ) u_step (
        .x      (xr_r),
        .y      (yr_r),
        .z      (z_r),
        .dir    (step_dir),
        .shift  (i_r),
        .atan   (atan_cur),
        .x_next (x_nxt),
        .y_next (y_nxt),
        .z_next (z_nxt)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [16:0]    GAIN_OP  = 17'(CORDIC_GAIN_INV);
    localparam logic [XW+16:0] HALF_LSB = (XW + 17)'(1) << 14;

    logic signed [XW+16:0] x_prod;
    logic signed [XW+16:0] y_prod;
    logic [XW+16:0]        x_rnd;
    logic [XW+16:0]        y_rnd;

    // Round half up: add 0.5 LSB, then floor via the bit slice
    always_comb begin
        x_prod = xr_r * $signed(GAIN_OP);
        y_prod = yr_r * $signed(GAIN_OP);
        x_rnd  = x_prod + HALF_LSB;
        y_rnd  = y_prod + HALF_LSB;
        res_x  = sat_drop(x_rnd[XW+14:15]);
        res_y  = sat_drop(y_rnd[XW+14:15]);
        res_z  = z_r;
    end
`else
    // Final stage feeds the output registers directly to save a cycle
    always_comb begin
        res_x = sat_drop(x_nxt);
        res_y = sat_drop(y_nxt);
        res_z = z_nxt;
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            angle_out    <= '0;
            sat_flag     <= 1'b0;
            xr_r         <= '0;
            yr_r         <= '0;
            z_r          <= '0;
            dirs_r       <= '0;
            i_r          <= '0;
            angle_mode_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        xr_r         <= {{GUARD_BITS{x_in[DATA_WIDTH-1]}}, x_in};
                        yr_r         <= {{GUARD_BITS{y_in[DATA_WIDTH-1]}}, y_in};
                        z_r          <= angle_microRot_n ? angle_in : '0;
                        dirs_r       <= micro_rot_in;
                        i_r          <= '0;
                        angle_mode_r <= angle_microRot_n;
                        in_ready     <= 1'b0;
                        state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    xr_r <= x_nxt;
                    yr_r <= y_nxt;
                    z_r  <= z_nxt;
                    i_r  <= i_r + 1'b1;
                    if (i_r == CW'(CORDIC_STAGES - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state <= ST_SCALE;
`else
                        x_out     <= res_x[DATA_WIDTH-1:0];
                        y_out     <= res_y[DATA_WIDTH-1:0];
                        sat_flag  <= res_x[DATA_WIDTH] | res_y[DATA_WIDTH];
                        angle_out <= res_z;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                ST_SCALE: begin
                    x_out     <= res_x[DATA_WIDTH-1:0];
                    y_out     <= res_y[DATA_WIDTH-1:0];
                    sat_flag  <= res_x[DATA_WIDTH] | res_y[DATA_WIDTH];
                    angle_out <= res_z;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rot_iter.sv
`timescale 1ns/1ps
module tb_cordic_rot_iter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int CS = 16;
    localparam int GB = 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif
    // posedges from accept to out_valid, and accept-to-accept period
    localparam int LAT     = COMP ? CS + 1 : CS;
    localparam int PERIOD  = LAT + 2;
    localparam int TIMEOUT = 200;
    localparam int NV      = 7;

    localparam int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                 41, 20, 10, 5, 3, 1, 1, 0};

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [15:0] angle_in = '0;
    logic [15:0] micro_rot_in = '0;
    logic        angle_microRot_n = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [15:0] angle_out;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [15:0] x, y, a, d;
        logic        m;
        bit          has_xy;
        int          ex, ey, txy;
        int          ez, tz;
        bit          chk_sat;
        logic        esat;
    } vec_t;

    vec_t vecs [NV];

    cordic_rot_iter #(
        .DATA_WIDTH    (DW),
        .ANGLE_WIDTH   (AW),
        .CORDIC_STAGES (CS),
        .GUARD_BITS    (GB)
    ) dut (
        .clk              (clk),
        .nreset           (nreset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .x_in             (x_in),
        .y_in             (y_in),
        .angle_in         (angle_in),
        .micro_rot_in     (micro_rot_in),
        .angle_microRot_n (angle_microRot_n),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .x_out            (x_out),
        .y_out            (y_out),
        .angle_out        (angle_out),
        .sat_flag         (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input string name, input logic [15:0] x, y, a, d,
                                input logic m, input bit has_xy, input int ex, ey, txy,
                                input int ez, tz, input bit chk_sat, input logic esat);
        vec_t v;
        v.name = name; v.x = x; v.y = y; v.a = a; v.d = d; v.m = m;
        v.has_xy = has_xy; v.ex = ex; v.ey = ey; v.txy = txy;
        v.ez = ez; v.tz = tz; v.chk_sat = chk_sat; v.esat = esat;
        return v;
    endfunction

    function automatic int clamp16(input int v, inout logic s);
        if (v > 32767) begin s = 1'b1; return 32767; end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return v;
    endfunction

    // Reference CORDIC in plain integer arithmetic
    function automatic void model(input logic [15:0] x, y, a, d, input logic m,
                                  output int ox, oy, oz, output logic os);
        int xr, yr, z, xt;
        logic [15:0] zz;
        logic dir;
        xr = int'($signed(x));
        yr = int'($signed(y));
        z  = m ? int'($signed(a)) : 0;
        for (int i = 0; i < CS; i++) begin
            zz  = 16'(z);
            dir = m ? zz[15] : d[i];
            xt  = xr;
            if (!dir) begin
                xr = xr - (yr >>> i); yr = yr + (xt >>> i); z = z - ATAN[i];
            end else begin
                xr = xr + (yr >>> i); yr = yr - (xt >>> i); z = z + ATAN[i];
            end
        end
        zz = 16'(z);
        oz = int'($signed(zz));
        if (COMP) begin
            xr = (xr * 19898 + 16384) >>> 15;
            yr = (yr * 19898 + 16384) >>> 15;
        end
        os = 1'b0;
        ox = clamp16(xr, os);
        oy = clamp16(yr, os);
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: got no response, expected one within %0d cycles", what, TIMEOUT);
    endtask

    task automatic send(input logic [15:0] x, y, a, d, input logic m);
        int n = 0;
        while (!in_ready && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        if (!in_ready) timeout_fail("in_ready wait");
        x_in = x; y_in = y; angle_in = a; micro_rot_in = d; angle_microRot_n = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (!out_valid && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        ok = out_valid;
        if (!ok) timeout_fail("out_valid wait");
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_model(input string name, input vec_t v);
        int mx, my, mz;
        logic ms;
        model(v.x, v.y, v.a, v.d, v.m, mx, my, mz, ms);
        chk({name, " x_out model"}, int'($signed(x_out)), mx, 0);
        chk({name, " y_out model"}, int'($signed(y_out)), my, 0);
        chk({name, " angle_out model"}, int'($signed(angle_out)), mz, 0);
        chk({name, " sat_flag model"}, int'(sat_flag), int'(ms), 0);
    endtask

    initial begin
        bit ok;
        int hx, hy, hz, mx, my, mz;
        logic ms;
        int acc [3];
        int nacc, rise, rise_x, n;
        logic prev_ov;

        vecs[0] = mk("ang45", 16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b1, 1'b1,
                     COMP ? 11585 : 19081, COMP ? 11585 : 19081, 4, 0, 2, 1'b1, 1'b0);
        vecs[1] = mk("sat_pos", 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 1'b1,
                     32767, 32767, COMP ? 12 : 0, 0, 2, !COMP, 1'b1);
        vecs[2] = mk("micro0", 16'h2000, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1,
                     COMP ? -1406 : -2315, COMP ? 8070 : 13290, 12, -18183, 2, 1'b1, 1'b0);
        vecs[3] = mk("microA5", 16'h1000, 16'h0800, 16'h0000, 16'hA5A5, 1'b0, 1'b0,
                     0, 0, 0, 4230, 0, 1'b1, 1'b0);
        vecs[4] = mk("ang_m45", 16'h4000, 16'h0000, 16'hE000, 16'h0000, 1'b1, 1'b1,
                     COMP ? 11585 : 19081, COMP ? -11585 : -19081, 10, 0, 2, 1'b1, 1'b0);
        vecs[5] = mk("ang90", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b1,
                     0, COMP ? 16384 : 26980, 10, 0, 2, 1'b1, 1'b0);
        vecs[6] = mk("sat_neg", 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1,
                     -32768, -32768, COMP ? 12 : 0, 0, 2, !COMP, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", int'(in_ready), 1, 0);
        chk("reset out_valid", int'(out_valid), 0, 0);
        chk("reset x_out", int'(x_out), 0, 0);
        chk("reset y_out", int'(y_out), 0, 0);
        chk("reset angle_out", int'(angle_out), 0, 0);
        chk("reset sat_flag", int'(sat_flag), 0, 0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int k = 0; k < NV; k++) begin
            send(vecs[k].x, vecs[k].y, vecs[k].a, vecs[k].d, vecs[k].m);
            wait_out(ok);
            if (ok) begin
                check_model(vecs[k].name, vecs[k]);
                if (vecs[k].has_xy) begin
                    chk({vecs[k].name, " x_out approx"}, int'($signed(x_out)), vecs[k].ex, vecs[k].txy);
                    chk({vecs[k].name, " y_out approx"}, int'($signed(y_out)), vecs[k].ey, vecs[k].txy);
                end
                chk({vecs[k].name, " angle_out approx"}, int'($signed(angle_out)), vecs[k].ez, vecs[k].tz);
                if (vecs[k].chk_sat)
                    chk({vecs[k].name, " sat_flag"}, int'(sat_flag), int'(vecs[k].esat), 0);
            end
            pop();
        end

        // Hold in DONE with out_ready low while a new sample is offered
        send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b1);
        wait_out(ok);
        hx = int'($signed(x_out));
        hy = int'($signed(y_out));
        hz = int'($signed(angle_out));
        model(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b1, mx, my, mz, ms);
        chk("hold first x_out", hx, mx, 0);
        x_in = 16'h1111; y_in = 16'h2222; angle_in = 16'h0100; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold out_valid", int'(out_valid), 1, 0);
            chk("hold in_ready", int'(in_ready), 0, 0);
            chk("hold x_out", int'($signed(x_out)), mx, 0);
            chk("hold y_out", int'($signed(y_out)), my, 0);
            chk("hold angle_out", int'($signed(angle_out)), mz, 0);
        end
        in_valid = 1'b0;
        pop();
        chk("hold release in_ready", int'(in_ready), 1, 0);
        chk("hold release out_valid", int'(out_valid), 0, 0);

        // Asynchronous reset while at BUSY stage 7
        send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b1);
        repeat (7) @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("midreset in_ready", int'(in_ready), 1, 0);
        chk("midreset out_valid", int'(out_valid), 0, 0);
        chk("midreset x_out", int'(x_out), 0, 0);
        chk("midreset y_out", int'(y_out), 0, 0);
        chk("midreset angle_out", int'(angle_out), 0, 0);
        @(posedge clk); #1;
        chk("midreset in_ready edge", int'(in_ready), 1, 0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("postreset out_valid", int'(out_valid), 0, 0);
        send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b1);
        wait_out(ok);
        if (ok) check_model("postreset", vecs[0]);
        pop();

        // Back-to-back traffic: accept period and latency
        nacc = 0; rise = -1; rise_x = 0; prev_ov = 1'b0;
        x_in = 16'h4000; y_in = 16'h0000; angle_in = 16'h2000; micro_rot_in = '0;
        angle_microRot_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (nacc < 3 && n < 4 * PERIOD + 20) begin
            @(negedge clk);
            if (in_valid && in_ready) begin acc[nacc] = cyc + 1; nacc++; end
            if (out_valid && !prev_ov && rise < 0) begin
                rise = cyc;
                rise_x = int'($signed(x_out));
            end
            prev_ov = out_valid;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (nacc < 3 || rise < 0) begin
            timeout_fail("back-to-back accepts");
        end else begin
            chk("accept period 1", acc[1] - acc[0], PERIOD, 0);
            chk("accept period 2", acc[2] - acc[1], PERIOD, 0);
            chk("latency cycles", rise - acc[0] + 1, LAT + 1, 0);
            chk("back-to-back x_out", rise_x, mx, 0);
        end
        n = 0;
        while (!in_ready && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        if (!in_ready) timeout_fail("drain");
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
